elevator_ctrl: RTL and testbench

ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

---
 rtl/elevator_ctrl_pkg.sv | 20 ++
 rtl/elevator_ctrl_if.sv | 33 +++
 rtl/elevator_timer.sv | 28 ++
 rtl/elevator_ctrl.sv | 134 +++++++++++++
 tb/tb_elevator_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/elevator_ctrl_pkg.sv
// Shared definitions for the elevator controller: one-hot state encoding,
// travel direction and state width, used by the RTL and the bench alike.
package elevator_ctrl_pkg;

  localparam int STATE_W = 5;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 5'b00001,
    S_UP   = 5'b00010,
    S_DOWN = 5'b00100,
    S_DOOR = 5'b01000,
    S_STOP = 5'b10000
  } state_t;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

endpackage

// File: rtl/elevator_ctrl_if.sv
// Request/status bundle between the car controller and its environment.
interface elevator_ctrl_if #(
  parameter int FLOORS = 8
);
  import elevator_ctrl_pkg::*;

  localparam int FW = $clog2(FLOORS);

  logic              halt;
  logic [FLOORS-1:0] call_req;
  logic [FW-1:0]     floor;
  logic              top_lim;
  logic              bott_lim;
  logic              door_open;
  logic              moving_up;
  logic              moving_down;
  logic [FLOORS-1:0] pending;
  state_t            estado;
  state_t            prox_estado;

  modport master (
    output halt, call_req,
    input  floor, top_lim, bott_lim, door_open, moving_up, moving_down,
           pending, estado, prox_estado
  );

  modport slave (
    input  halt, call_req,
    output floor, top_lim, bott_lim, door_open, moving_up, moving_down,
           pending, estado, prox_estado
  );

endinterface

// File: rtl/elevator_timer.sv
// Shared cycle counter for floor travel and door dwell; tc flags the last
// cycle of the interval selected by 'last'.
module elevator_timer #(
  parameter int W = 2
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] last,
  output logic         tc
);

  logic [W-1:0] count;

  assign tc = (count == last);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tc ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/elevator_ctrl.sv
// Single-car elevator controller: latches floor calls, serves them in SCAN
// order, holds the door for a fixed dwell and obeys an emergency halt.
module elevator_ctrl
  import elevator_ctrl_pkg::*;
#(
  parameter int FLOORS        = 8,
  parameter int TRAVEL_CYCLES = 3,
  parameter int DOOR_CYCLES   = 4
) (
  input  logic           CLK,
  input  logic           reset,
  elevator_ctrl_if.slave bus
);

  localparam int FW   = $clog2(FLOORS);
  localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [FW-1:0] TOP       = FW'(FLOORS - 1);
  localparam logic [TW-1:0] TRAV_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LAST = TW'(DOOR_CYCLES - 1);

  state_t            state, nxt;
  dir_t              dir_q;
  logic [FW-1:0]     floor_q, nf;
  logic [FLOORS-1:0] pend_q, pend_nxt, door_bit;
  logic [TW-1:0]     tmr_last;
  logic              tc, tmr_clear, tmr_en, door_call, moving;
  logic              door_q, up_q, dn_q, top_q, bott_q;

  // Stationary decision at floor f: serve here, else head for outstanding
  // calls, preferring the last travel direction when both sides have work.
  function automatic state_t choose(input logic [FLOORS-1:0] p,
                                    input logic [FW-1:0]     f,
                                    input dir_t              d);
    logic up_any, dn_any;
    up_any = 1'b0;
    dn_any = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (p[i] && (i > int'(f))) up_any = 1'b1;
      if (p[i] && (i < int'(f))) dn_any = 1'b1;
    end
    if (p[f])                                    choose = S_DOOR;
    else if (up_any && (!dn_any || d == DIR_UP)) choose = S_UP;
    else if (dn_any)                             choose = S_DOWN;
    else                                         choose = S_IDLE;
  endfunction

  elevator_timer #(.W(TW)) u_timer (
    .CLK    (CLK),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .last   (tmr_last),
    .tc     (tc)
  );

  always_comb begin
    moving    = (state == S_UP) || (state == S_DOWN);
    door_call = (state == S_DOOR) && bus.call_req[floor_q];
    tmr_en    = moving || (state == S_DOOR);
    tmr_last  = (state == S_DOOR) ? DOOR_LAST : TRAV_LAST;
    nf        = floor_q;
    nxt       = state;
    case (state)
      S_IDLE: nxt = choose(pend_q, floor_q, dir_q);
      S_UP: begin
        if (floor_q == TOP) begin
          nxt = S_IDLE;
        end else if (tc) begin
          nf  = floor_q + FW'(1);
          nxt = choose(pend_q, nf, dir_q);
        end
      end
      S_DOWN: begin
        if (floor_q == '0) begin
          nxt = S_IDLE;
        end else if (tc) begin
          nf  = floor_q - FW'(1);
          nxt = choose(pend_q, nf, dir_q);
        end
      end
      S_DOOR: begin
        // A call for this floor keeps the door open instead of queueing.
        if (door_call)  nxt = S_DOOR;
        else if (tc)    nxt = choose(pend_q, floor_q, dir_q);
      end
      default: nxt = S_IDLE;
    endcase
    if (bus.halt) begin
      nxt = S_STOP;
      nf  = floor_q;
    end
    tmr_clear = bus.halt || (nxt != state) || (moving && tc) || door_call;
    door_bit  = (nxt == S_DOOR) ? (FLOORS'(1) << nf) : '0;
    pend_nxt  = (pend_q | bus.call_req) & ~door_bit;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      dir_q   <= DIR_UP;
      floor_q <= '0;
      pend_q  <= '0;
      door_q  <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      top_q   <= 1'b0;
      bott_q  <= 1'b1;
    end else begin
      state   <= nxt;
      floor_q <= nf;
      pend_q  <= pend_nxt;
      if (nxt == S_UP)        dir_q <= DIR_UP;
      else if (nxt == S_DOWN) dir_q <= DIR_DOWN;
      door_q  <= (nxt == S_DOOR);
      up_q    <= (nxt == S_UP);
      dn_q    <= (nxt == S_DOWN);
      top_q   <= (nf == TOP);
      bott_q  <= (nf == '0);
    end
  end

  assign bus.estado      = state;
  assign bus.prox_estado = nxt;
  assign bus.floor       = floor_q;
  assign bus.pending     = pend_q;
  assign bus.door_open   = door_q;
  assign bus.moving_up   = up_q;
  assign bus.moving_down = dn_q;
  assign bus.top_lim     = top_q;
  assign bus.bott_lim    = bott_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl (FLOORS=8, TRAVEL_CYCLES=3, DOOR_CYCLES=4).
module tb_elevator_ctrl;
  import elevator_ctrl_pkg::*;

  logic CLK;
  logic reset;
  int   npass;
  int   nchk;

  elevator_ctrl_if #(.FLOORS(8)) bus ();

  elevator_ctrl #(
    .FLOORS        (8),
    .TRAVEL_CYCLES (3),
    .DOOR_CYCLES   (4)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".estado"},   32'(bus.estado),      32'(S_IDLE));
    chk({tag, ".prox"},     32'(bus.prox_estado), 32'(S_IDLE));
    chk({tag, ".floor"},    32'(bus.floor),       0);
    chk({tag, ".pending"},  32'(bus.pending),     0);
    chk({tag, ".door"},     32'(bus.door_open),   0);
    chk({tag, ".mv_up"},    32'(bus.moving_up),   0);
    chk({tag, ".mv_dn"},    32'(bus.moving_down), 0);
    chk({tag, ".bott_lim"}, 32'(bus.bott_lim),    1);
    chk({tag, ".top_lim"},  32'(bus.top_lim),     0);
  endtask

  initial begin
    npass        = 0;
    nchk         = 0;
    reset        = 1'b0;
    bus.halt     = 1'b0;
    bus.call_req = '0;
    step(2);
    chk_reset_vals("rst");

    // Single call to floor 2
    reset        = 1'b1;
    bus.call_req = 8'h04;
    step(1);                                   // E0
    chk("e0.pending", 32'(bus.pending), 32'h04);
    chk("e0.estado",  32'(bus.estado), 32'(S_IDLE));
    chk("e0.prox",    32'(bus.prox_estado), 32'(S_UP));
    bus.call_req = '0;
    step(1);                                   // E1
    chk("e1.estado", 32'(bus.estado), 32'(S_UP));
    chk("e1.mv_up",  32'(bus.moving_up), 1);
    chk("e1.floor",  32'(bus.floor), 0);
    step(3);                                   // E4
    chk("e4.floor",    32'(bus.floor), 1);
    chk("e4.bott_lim", 32'(bus.bott_lim), 0);
    step(2);                                   // E6
    chk("e6.prox",  32'(bus.prox_estado), 32'(S_DOOR));
    chk("e6.floor", 32'(bus.floor), 1);
    step(1);                                   // E7
    chk("e7.floor",   32'(bus.floor), 2);
    chk("e7.estado",  32'(bus.estado), 32'(S_DOOR));
    chk("e7.door",    32'(bus.door_open), 1);
    chk("e7.pending", 32'(bus.pending), 0);
    step(3);                                   // E10
    chk("e10.door", 32'(bus.door_open), 1);
    step(1);                                   // E11
    chk("e11.estado",  32'(bus.estado), 32'(S_IDLE));
    chk("e11.door",    32'(bus.door_open), 0);
    chk("e11.pending", 32'(bus.pending), 0);

    // Door restart from a same-floor call
    bus.call_req = 8'h04;
    step(1);                                   // E12
    chk("e12.pending", 32'(bus.pending), 32'h04);
    bus.call_req = '0;
    step(1);                                   // E13
    chk("e13.estado",  32'(bus.estado), 32'(S_DOOR));
    chk("e13.pending", 32'(bus.pending), 0);
    step(2);                                   // E15, third door cycle
    bus.call_req = 8'h04;
    step(1);                                   // E16
    bus.call_req = '0;
    chk("e16.door",    32'(bus.door_open), 1);
    chk("e16.pending", 32'(bus.pending), 0);
    step(1);                                   // E17
    chk("e17.door", 32'(bus.door_open), 1);
    step(2);                                   // E19
    chk("e19.estado", 32'(bus.estado), 32'(S_DOOR));
    step(1);                                   // E20
    chk("e20.estado", 32'(bus.estado), 32'(S_IDLE));
    chk("e20.door",   32'(bus.door_open), 0);

    // Move to floor 3
    bus.call_req = 8'h08;
    step(1);
    bus.call_req = '0;
    step(4);
    chk("f3.floor",  32'(bus.floor), 3);
    chk("f3.estado", 32'(bus.estado), 32'(S_DOOR));
    step(4);
    chk("f3.idle", 32'(bus.estado), 32'(S_IDLE));

    // SCAN tie-break: calls at 7 and 0 from floor 3, last direction up
    bus.call_req = 8'h81;
    step(1);                                   // B
    chk("b.pending", 32'(bus.pending), 32'h81);
    bus.call_req = '0;
    step(1);                                   // B+1
    chk("b1.estado", 32'(bus.estado), 32'(S_UP));
    step(12);                                  // B+13
    chk("b13.floor",   32'(bus.floor), 7);
    chk("b13.estado",  32'(bus.estado), 32'(S_DOOR));
    chk("b13.top_lim", 32'(bus.top_lim), 1);
    chk("b13.pending", 32'(bus.pending), 32'h01);
    step(4);                                   // B+17
    chk("b17.estado", 32'(bus.estado), 32'(S_DOWN));
    chk("b17.mv_dn",  32'(bus.moving_down), 1);
    chk("b17.floor",  32'(bus.floor), 7);
    step(21);                                  // B+38
    chk("b38.floor",    32'(bus.floor), 0);
    chk("b38.estado",   32'(bus.estado), 32'(S_DOOR));
    chk("b38.bott_lim", 32'(bus.bott_lim), 1);
    chk("b38.top_lim",  32'(bus.top_lim), 0);
    chk("b38.pending",  32'(bus.pending), 0);
    step(4);                                   // B+42
    chk("b42.estado", 32'(bus.estado), 32'(S_IDLE));

    // Halt between floors 1 and 2
    bus.call_req = 8'h04;
    step(1);                                   // C
    bus.call_req = '0;
    step(5);                                   // C+5
    chk("c5.floor",  32'(bus.floor), 1);
    chk("c5.estado", 32'(bus.estado), 32'(S_UP));
    bus.halt = 1'b1;
    step(1);                                   // C+6
    chk("c6.estado",  32'(bus.estado), 32'(S_STOP));
    chk("c6.floor",   32'(bus.floor), 1);
    chk("c6.pending", 32'(bus.pending), 32'h04);
    chk("c6.door",    32'(bus.door_open), 0);
    chk("c6.mv_up",   32'(bus.moving_up), 0);
    bus.call_req = 8'h20;
    step(1);                                   // C+7
    chk("c7.estado",  32'(bus.estado), 32'(S_STOP));
    chk("c7.pending", 32'(bus.pending), 32'h24);
    bus.call_req = '0;
    bus.halt     = 1'b0;
    step(1);                                   // C+8
    chk("c8.estado", 32'(bus.estado), 32'(S_IDLE));
    chk("c8.floor",  32'(bus.floor), 1);
    step(1);                                   // C+9
    chk("c9.estado", 32'(bus.estado), 32'(S_UP));
    step(2);                                   // C+11
    chk("c11.floor", 32'(bus.floor), 1);
    step(1);                                   // C+12
    chk("c12.floor",   32'(bus.floor), 2);
    chk("c12.estado",  32'(bus.estado), 32'(S_DOOR));
    chk("c12.pending", 32'(bus.pending), 32'h20);

    // Asynchronous reset while the door is open at floor 5
    step(13);                                  // C+25
    chk("c25.floor",  32'(bus.floor), 5);
    chk("c25.estado", 32'(bus.estado), 32'(S_DOOR));
    bus.call_req = 8'h40;
    step(1);                                   // C+26
    bus.call_req = '0;
    chk("c26.pending", 32'(bus.pending), 32'h40);
    #2 reset = 1'b0;
    #1;
    chk_reset_vals("arst");
    #2 reset = 1'b1;
    step(2);
    chk("post.estado",  32'(bus.estado), 32'(S_IDLE));
    chk("post.pending", 32'(bus.pending), 0);
    chk("post.floor",   32'(bus.floor), 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
